pipe_ctrl: RTL and testbench

- Sequencing controller for the 3-stage (fetch/decode/execute) processor.
- Drives the enable and clear inputs of the PC, the IF/ID and ID/EX pipeline registers (built from 4-bit enable/reset register slices) and the register-file write enable.
- Handles pipeline fill, multi-cycle execute stalls, read-after-write hazards, taken-branch flushes and HALT drain.
- Sits beside the datapath and owns no data, only valid bits, a latency counter and the run state.

---
 rtl/pipe_pkg.sv | 55 +++++
 rtl/pipe_ctrl_if.sv | 51 +++++
 rtl/hazard_unit.sv | 38 +++
 rtl/pipe_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the 3-stage pipeline sequencing controller:
//   - default register-file address width and execute latency-count width
//   - controller run-state enum
//   - bundle of pipeline-register enable/clear strobes, with named presets
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int DEF_REG_AW = 4;
    localparam int DEF_LAT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_e;

    // Strobes that steer the PC and the two pipeline registers.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_clr;
        logic idex_en;
        logic idex_clr;
    } pipe_ctl_t;

    // Everything frozen: idle, multi-cycle stall, or drain retire.
    localparam pipe_ctl_t CTL_NONE = '{
        pc_en: 1'b0, ifid_en: 1'b0, ifid_clr: 1'b0, idex_en: 1'b0, idex_clr: 1'b0
    };

    // Normal advance of every stage.
    localparam pipe_ctl_t CTL_ADV = '{
        pc_en: 1'b1, ifid_en: 1'b1, ifid_clr: 1'b0, idex_en: 1'b1, idex_clr: 1'b0
    };

    // Taken branch: PC loads the target, both younger stages are squashed.
    localparam pipe_ctl_t CTL_FLUSH = '{
        pc_en: 1'b1, ifid_en: 1'b0, ifid_clr: 1'b1, idex_en: 1'b0, idex_clr: 1'b1
    };

    // RAW hazard: fetch and decode hold, a bubble goes into execute.
    localparam pipe_ctl_t CTL_BUBBLE = '{
        pc_en: 1'b0, ifid_en: 1'b0, ifid_clr: 1'b0, idex_en: 1'b0, idex_clr: 1'b1
    };

    // HALT accepted: nothing new is fetched, the HALT itself is dropped.
    localparam pipe_ctl_t CTL_HALT = '{
        pc_en: 1'b0, ifid_en: 1'b0, ifid_clr: 1'b1, idex_en: 1'b0, idex_clr: 1'b1
    };

endpackage

// File: rtl/pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_if
// Bundle between the datapath and the pipeline controller.
//   Datapath -> controller : start, halt_dec, id_rs1, id_rs2, id_uses_rs2,
//                            ex_rd, ex_wr, ex_lat, br_taken
//   Controller -> datapath : pc_en, ifid_en, ifid_clr, idex_en, idex_clr,
//                            rf_we, id_valid, ex_valid, halted
// Modports:
//   master : the controller, which drives the pipeline strobes
//   slave  : the datapath side (or a testbench standing in for it)
// -----------------------------------------------------------------------------
interface pipe_ctrl_if #(
    parameter int REG_AW = pipe_pkg::DEF_REG_AW,
    parameter int LAT_W  = pipe_pkg::DEF_LAT_W
) ();

    logic              start;
    logic              halt_dec;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_uses_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_wr;
    logic [LAT_W-1:0]  ex_lat;
    logic              br_taken;

    logic              pc_en;
    logic              ifid_en;
    logic              ifid_clr;
    logic              idex_en;
    logic              idex_clr;
    logic              rf_we;
    logic              id_valid;
    logic              ex_valid;
    logic              halted;

    modport master (
        input  start, halt_dec, id_rs1, id_rs2, id_uses_rs2,
               ex_rd, ex_wr, ex_lat, br_taken,
        output pc_en, ifid_en, ifid_clr, idex_en, idex_clr,
               rf_we, id_valid, ex_valid, halted
    );

    modport slave (
        output start, halt_dec, id_rs1, id_rs2, id_uses_rs2,
               ex_rd, ex_wr, ex_lat, br_taken,
        input  pc_en, ifid_en, ifid_clr, idex_en, idex_clr,
               rf_we, id_valid, ex_valid, halted
    );

endinterface

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// Combinational read-after-write check between the decode instruction and the
// instruction in execute. Kept separate so a forwarding network can reuse the
// same comparators later.
// Ports:
//   i_id_valid    decode holds a real instruction
//   i_ex_valid    execute holds a real instruction
//   i_ex_wr       execute instruction writes a register
//   i_id_rs1      decode source register 1
//   i_id_rs2      decode source register 2
//   i_id_uses_rs2 decode instruction actually reads rs2
//   i_ex_rd       execute destination register
//   o_hazard      decode must wait one cycle for the write-back
// -----------------------------------------------------------------------------
module hazard_unit #(
    parameter int REG_AW = pipe_pkg::DEF_REG_AW
) (
    input  logic              i_id_valid,
    input  logic              i_ex_valid,
    input  logic              i_ex_wr,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_id_uses_rs2,
    input  logic [REG_AW-1:0] i_ex_rd,
    output logic              o_hazard
);

    logic w_rs1_match;
    logic w_rs2_match;

    assign w_rs1_match = (i_id_rs1 == i_ex_rd);
    // rs2 only counts when the opcode reads it; immediates reuse that field.
    assign w_rs2_match = i_id_uses_rs2 & (i_id_rs2 == i_ex_rd);

    assign o_hazard = i_id_valid & i_ex_valid & i_ex_wr & (w_rs1_match | w_rs2_match);

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Sequencing controller for the fetch/decode/execute pipeline. Owns only the
// stage valid bits, the execute extra-latency counter and the run state; it
// steers the PC, IF/ID and ID/EX registers and the register-file write strobe.
// Ports:
//   clk     rising-edge clock
//   res     synchronous active-high reset, dominant over every other input
//   io_bus  pipe_ctrl_if.master (datapath status in, pipeline strobes out)
// Stall priority in RUN, highest first: multi-cycle execute, taken branch,
// RAW hazard, HALT in decode, normal advance.
// -----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int REG_AW = pipe_pkg::DEF_REG_AW,
    parameter int LAT_W  = pipe_pkg::DEF_LAT_W
) (
    input  logic        clk,
    input  logic        res,
    pipe_ctrl_if.master io_bus
);

    import pipe_pkg::*;

    state_e           r_state;
    logic             r_id_valid;
    logic             r_ex_valid;
    logic [LAT_W-1:0] r_ex_cnt;

    state_e           w_state_nxt;
    logic             w_id_valid_nxt;
    logic             w_ex_valid_nxt;
    logic [LAT_W-1:0] w_ex_cnt_nxt;
    pipe_ctl_t        w_ctl;

    logic             w_active;
    logic             w_ex_busy;
    logic             w_ex_done;
    logic             w_hazard;

    assign w_active  = (r_state == RUN) || (r_state == DRAIN);
    assign w_ex_busy = r_ex_valid & (r_ex_cnt != '0);
    assign w_ex_done = r_ex_valid & (r_ex_cnt == '0);

    hazard_unit #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .i_id_valid    (r_id_valid),
        .i_ex_valid    (r_ex_valid),
        .i_ex_wr       (io_bus.ex_wr),
        .i_id_rs1      (io_bus.id_rs1),
        .i_id_rs2      (io_bus.id_rs2),
        .i_id_uses_rs2 (io_bus.id_uses_rs2),
        .i_ex_rd       (io_bus.ex_rd),
        .o_hazard      (w_hazard)
    );

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: only control state lives here and all of it is reset; the
    // controller holds no data storage that would need to be left unreset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (res) begin
            r_state    <= IDLE;
            r_id_valid <= 1'b0;
            r_ex_valid <= 1'b0;
            r_ex_cnt   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_id_valid <= w_id_valid_nxt;
            r_ex_valid <= w_ex_valid_nxt;
            r_ex_cnt   <= w_ex_cnt_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and pipeline strobes
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // through the case tree can leave one unassigned and infer a latch.
        w_state_nxt    = r_state;
        w_id_valid_nxt = r_id_valid;
        w_ex_valid_nxt = r_ex_valid;
        w_ex_cnt_nxt   = r_ex_cnt;
        w_ctl          = CTL_NONE;

        unique case (r_state)
            IDLE, HALTED: begin
                w_id_valid_nxt = 1'b0;
                w_ex_valid_nxt = 1'b0;
                w_ex_cnt_nxt   = '0;
                if (io_bus.start) begin
                    w_state_nxt = RUN;
                end
            end

            RUN: begin
                if (w_ex_busy) begin
                    // Counter only moves while non-zero, so it never wraps.
                    w_ex_cnt_nxt = r_ex_cnt - LAT_W'(1);
                end else if (w_ex_done & io_bus.br_taken) begin
                    w_ctl          = CTL_FLUSH;
                    w_id_valid_nxt = 1'b0;
                    w_ex_valid_nxt = 1'b0;
                end else if (w_hazard) begin
                    // The producer writes back at this same edge, so a single
                    // bubble is enough for decode to read the new value.
                    w_ctl          = CTL_BUBBLE;
                    w_ex_valid_nxt = 1'b0;
                end else if (r_id_valid & io_bus.halt_dec) begin
                    // A busy producer was caught by the first branch, so the
                    // execute instruction retires now and HALT never enters EX.
                    w_ctl          = CTL_HALT;
                    w_id_valid_nxt = 1'b0;
                    w_ex_valid_nxt = 1'b0;
                    w_state_nxt    = DRAIN;
                end else begin
                    w_ctl          = CTL_ADV;
                    w_id_valid_nxt = 1'b1;
                    w_ex_valid_nxt = r_id_valid;
                    w_ex_cnt_nxt   = r_id_valid ? io_bus.ex_lat : '0;
                end
            end

            DRAIN: begin
                if (w_ex_busy) begin
                    w_ex_cnt_nxt = r_ex_cnt - LAT_W'(1);
                end else if (w_ex_done & io_bus.br_taken) begin
                    // A taken branch older than the HALT squashes it.
                    w_ctl          = CTL_FLUSH;
                    w_id_valid_nxt = 1'b0;
                    w_ex_valid_nxt = 1'b0;
                    w_state_nxt    = RUN;
                end else begin
                    w_ex_valid_nxt = 1'b0;
                    w_state_nxt    = HALTED;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign io_bus.pc_en    = w_ctl.pc_en;
    assign io_bus.ifid_en  = w_ctl.ifid_en;
    assign io_bus.ifid_clr = w_ctl.ifid_clr;
    assign io_bus.idex_en  = w_ctl.idex_en;
    assign io_bus.idex_clr = w_ctl.idex_clr;
    // Write-back fires on the single cycle the execute instruction completes.
    assign io_bus.rf_we    = w_active & w_ex_done & io_bus.ex_wr;
    assign io_bus.id_valid = r_id_valid;
    assign io_bus.ex_valid = r_ex_valid;
    assign io_bus.halted   = (r_state == HALTED);

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl: a table of directed cycles, a few
// multi-cycle sequences, then randomized traffic against an action-level
// reference model. Output vector order everywhere:
//   {pc_en, ifid_en, ifid_clr, idex_en, idex_clr, rf_we, id_valid, ex_valid, halted}
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    logic clk;
    logic res;

    pipe_ctrl_if #(.REG_AW(4), .LAT_W(4)) bus ();

    pipe_ctrl #(.REG_AW(4), .LAT_W(4)) dut (
        .clk    (clk),
        .res    (res),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string      name;
        bit         res;
        bit         start;
        bit         halt;
        logic [3:0] rs1;
        logic [3:0] rs2;
        bit         uses2;
        logic [3:0] rd;
        bit         wr;
        logic [3:0] lat;
        bit         br;
        logic [8:0] exp;
    } vec_t;

    function automatic vec_t mk(string name, bit r, bit st, bit h, int rs1, int rs2,
                                bit u2, int rd, bit wr, int lat, bit br, logic [8:0] exp);
        vec_t v;
        v.name = name; v.res = r; v.start = st; v.halt = h;
        v.rs1 = 4'(rs1); v.rs2 = 4'(rs2); v.uses2 = u2; v.rd = 4'(rd);
        v.wr = wr; v.lat = 4'(lat); v.br = br; v.exp = exp;
        return v;
    endfunction

    function automatic logic [8:0] dut_outs();
        return {bus.pc_en, bus.ifid_en, bus.ifid_clr, bus.idex_en, bus.idex_clr,
                bus.rf_we, bus.id_valid, bus.ex_valid, bus.halted};
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        res             = v.res;
        bus.start       = v.start;
        bus.halt_dec    = v.halt;
        bus.id_rs1      = v.rs1;
        bus.id_rs2      = v.rs2;
        bus.id_uses_rs2 = v.uses2;
        bus.ex_rd       = v.rd;
        bus.ex_wr       = v.wr;
        bus.ex_lat      = v.lat;
        bus.br_taken    = v.br;
    endtask

    // One clock: drive after the edge, compare mid-cycle.
    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        drive(v);
        @(negedge clk);
        check(v.name, dut_outs(), v.exp);
    endtask

    // ------------------------------------------------------------------------
    // Reference model: decides one action per cycle from the rules, then
    // derives both the strobes and the next occupancy from that action.
    // ------------------------------------------------------------------------
    typedef enum {M_IDLE, M_RUN, M_DRAIN, M_HALTED} mmode_e;
    typedef enum {A_IDLE, A_STALL, A_FLUSH, A_BUBBLE, A_HALT, A_ADV, A_RETIRE} act_e;

    mmode_e m_mode;
    bit     m_id;
    bit     m_ex;
    int     m_left;

    function automatic act_e m_action();
        bit haz;
        if (m_mode == M_IDLE || m_mode == M_HALTED) return A_IDLE;
        if (m_ex && m_left > 0) return A_STALL;
        if (m_ex && bus.br_taken) return A_FLUSH;
        if (m_mode == M_DRAIN) return A_RETIRE;
        haz = m_id && m_ex && bus.ex_wr &&
              (bus.id_rs1 == bus.ex_rd || (bus.id_uses_rs2 && bus.id_rs2 == bus.ex_rd));
        if (haz) return A_BUBBLE;
        if (m_id && bus.halt_dec) return A_HALT;
        return A_ADV;
    endfunction

    function automatic logic [8:0] m_outs();
        logic [4:0] ctl;
        bit         we;
        case (m_action())
            A_FLUSH:  ctl = 5'b10101;
            A_BUBBLE: ctl = 5'b00001;
            A_HALT:   ctl = 5'b00101;
            A_ADV:    ctl = 5'b11010;
            default:  ctl = 5'b00000;
        endcase
        we = (m_mode == M_RUN || m_mode == M_DRAIN) && m_ex && m_left == 0 && bus.ex_wr;
        return {ctl, we, m_id, m_ex, m_mode == M_HALTED};
    endfunction

    task automatic m_advance();
        act_e a;
        a = m_action();
        if (res) begin
            m_mode = M_IDLE; m_id = 0; m_ex = 0; m_left = 0;
            return;
        end
        case (a)
            A_IDLE: begin
                m_id = 0; m_ex = 0; m_left = 0;
                if (bus.start) m_mode = M_RUN;
            end
            A_STALL:  m_left--;
            A_FLUSH:  begin m_id = 0; m_ex = 0; m_mode = M_RUN; end
            A_BUBBLE: m_ex = 0;
            A_HALT:   begin m_id = 0; m_ex = 0; m_mode = M_DRAIN; end
            A_RETIRE: begin m_ex = 0; m_mode = M_HALTED; end
            A_ADV: begin
                m_left = m_id ? int'(bus.ex_lat) : 0;
                m_ex   = m_id;
                m_id   = 1;
            end
            default: ;
        endcase
    endtask

    vec_t tbl[$];

    initial begin
        // Directed cycles: reset, fill, multi-cycle write, RAW stalls, branch,
        // HALT behind a 2-cycle write, restart from HALTED.
        tbl.push_back(mk("rst0",        1,0,0, 0,0,0, 0,0, 0,0, 9'b000000000));
        tbl.push_back(mk("rst1",        1,0,0, 0,0,0, 0,0, 0,0, 9'b000000000));
        tbl.push_back(mk("idle_start",  0,1,0, 0,0,0, 0,0, 0,0, 9'b000000000));
        tbl.push_back(mk("fill0",       0,0,0, 0,0,0, 0,0, 0,0, 9'b110100000));
        tbl.push_back(mk("fill1",       0,0,0, 1,0,0, 0,0, 3,0, 9'b110100100));
        tbl.push_back(mk("lat_busy3",   0,0,0, 1,0,0, 5,1, 0,0, 9'b000000110));
        tbl.push_back(mk("lat_busy2",   0,0,0, 1,0,0, 5,1, 0,0, 9'b000000110));
        tbl.push_back(mk("lat_busy1",   0,0,0, 1,0,0, 5,1, 0,0, 9'b000000110));
        tbl.push_back(mk("lat_done_we", 0,0,0, 1,0,0, 5,1, 0,0, 9'b110101110));
        tbl.push_back(mk("haz_rs1",     0,0,0, 5,0,0, 5,1, 0,0, 9'b000011110));
        tbl.push_back(mk("haz_release", 0,0,0, 5,0,0, 5,1, 0,0, 9'b110100100));
        tbl.push_back(mk("rs2_unused",  0,0,0, 2,5,0, 5,1, 0,0, 9'b110101110));
        tbl.push_back(mk("haz_rs2",     0,0,0, 2,5,1, 5,1, 0,0, 9'b000011110));
        tbl.push_back(mk("pre_branch",  0,0,0, 0,0,0, 0,0, 0,0, 9'b110100100));
        tbl.push_back(mk("br_flush",    0,0,0, 0,0,0, 0,0, 0,1, 9'b101010110));
        tbl.push_back(mk("br_pen1",     0,0,0, 0,0,0, 0,0, 0,0, 9'b110100000));
        tbl.push_back(mk("br_pen2",     0,0,0, 0,0,0, 0,0, 2,0, 9'b110100100));
        tbl.push_back(mk("halt_busy2",  0,0,1, 0,0,0, 7,1, 0,0, 9'b000000110));
        tbl.push_back(mk("halt_busy1",  0,0,1, 0,0,0, 7,1, 0,0, 9'b000000110));
        tbl.push_back(mk("halt_accept", 0,0,1, 0,0,0, 7,1, 0,0, 9'b001011110));
        tbl.push_back(mk("drain",       0,0,0, 0,0,0, 0,0, 0,0, 9'b000000000));
        tbl.push_back(mk("halted0",     0,0,0, 0,0,0, 0,0, 0,0, 9'b000000001));
        tbl.push_back(mk("halted1",     0,0,1, 0,0,0, 0,1, 0,1, 9'b000000001));
        tbl.push_back(mk("halted_start",0,1,0, 0,0,0, 0,0, 0,0, 9'b000000001));
        tbl.push_back(mk("restart",     0,0,0, 0,0,0, 0,0, 0,0, 9'b110100000));

        res = 1'b1;
        drive(mk("init", 1,0,0, 0,0,0, 0,0, 0,0, 9'b0));
        @(posedge clk);

        foreach (tbl[i]) apply(tbl[i]);

        // HALT in decode behind a taken branch: branch wins, no halt.
        apply(mk("brh_fill",   0,0,0, 0,0,0, 0,0, 1,0, 9'b110100100));
        apply(mk("brh_busy",   0,0,1, 0,0,0, 0,0, 0,1, 9'b000000110));
        apply(mk("brh_flush",  0,0,1, 0,0,0, 0,0, 0,1, 9'b101010110));
        apply(mk("brh_run",    0,0,0, 0,0,0, 0,0, 0,0, 9'b110100000));

        // Reset landing in the middle of a multi-cycle stall.
        apply(mk("rs_fill",    0,0,0, 0,0,0, 0,0, 3,0, 9'b110100100));
        apply(mk("rs_busy3",   0,0,0, 0,0,0, 0,0, 0,0, 9'b000000110));
        apply(mk("rs_assert",  1,0,0, 0,0,0, 0,0, 0,0, 9'b000000110));
        apply(mk("rs_idle",    0,0,0, 0,0,0, 0,0, 0,0, 9'b000000000));
        check("rs_cnt_clear", {5'b0, dut.r_ex_cnt}, 9'b0);
        apply(mk("rs_start",   0,1,0, 0,0,0, 0,0, 0,0, 9'b000000000));
        apply(mk("rs_run",     0,0,0, 0,0,0, 0,0, 0,0, 9'b110100000));

        // Randomized traffic against the reference model, from a clean reset.
        @(posedge clk);
        #1;
        drive(mk("rnd_rst", 1,0,0, 0,0,0, 0,0, 0,0, 9'b0));
        m_mode = M_IDLE; m_id = 0; m_ex = 0; m_left = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            res             = ($urandom_range(0, 149) == 0);
            bus.start       = ($urandom_range(0, 7) == 0);
            bus.halt_dec    = ($urandom_range(0, 11) == 0);
            bus.id_rs1      = 4'($urandom_range(0, 3));
            bus.id_rs2      = 4'($urandom_range(0, 3));
            bus.id_uses_rs2 = 1'($urandom_range(0, 1));
            bus.ex_rd       = 4'($urandom_range(0, 3));
            bus.ex_wr       = 1'($urandom_range(0, 1));
            bus.ex_lat      = ($urandom_range(0, 24) == 0) ? 4'd15 : 4'($urandom_range(0, 2));
            bus.br_taken    = ($urandom_range(0, 5) == 0);
            @(negedge clk);
            check("random", dut_outs(), m_outs());
            m_advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
